// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the register-specified shift sequencer:
//   - shifter type codes as carried in shift_operand[6:5] (LSL/LSR/ASR/ROR)
//   - sequencer state encoding
//   - 6-bit remaining-count type (holds 0..32)
// ---------------------------------------------------------------------------
package arm_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [5:0] rem_t;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter used by reg_shift_sequencer. Shifts the
// working value by k bits (k = 0 passes the value through) and reports the
// last bit shifted out.
// Ports:
//   val_i   [31:0]  working value
//   typ_i   [1:0]   shift type (SH_LSL/SH_LSR/SH_ASR/SH_ROR)
//   k_i     rem_t   bits to shift this step, 0..32
//   val_o   [31:0]  shifted value
//   carry_o         last bit shifted out (0 when k_i = 0)
// ---------------------------------------------------------------------------
module shift_step
    import arm_pkg::*;
(
    input  logic [31:0] val_i,
    input  logic [1:0]  typ_i,
    input  rem_t        k_i,
    output logic [31:0] val_o,
    output logic        carry_o
);

    // Bit positions of the last bit leaving the word: 32-k for left shifts,
    // k-1 for right shifts/rotates. Only meaningful for k in 1..32.
    logic [4:0] lsl_idx;
    logic [4:0] rsh_idx;

    assign lsl_idx = 5'(6'd32 - k_i);
    assign rsh_idx = 5'(k_i - 6'd1);

    always_comb begin
        val_o   = val_i;
        carry_o = 1'b0;
        if (k_i != '0) begin
            case (typ_i)
                SH_LSL: begin
                    val_o   = val_i << k_i;
                    carry_o = val_i[lsl_idx];
                end
                SH_LSR: begin
                    val_o   = val_i >> k_i;
                    carry_o = val_i[rsh_idx];
                end
                SH_ASR: begin
                    val_o   = $signed(val_i) >>> k_i;
                    carry_o = val_i[rsh_idx];
                end
                default: begin
                    val_o   = (val_i >> k_i) | (val_i << (6'd32 - k_i));
                    carry_o = val_i[rsh_idx];
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_shift_sequencer.sv
// ---------------------------------------------------------------------------
// reg_shift_sequencer
// Multi-cycle controller for register-specified shifts (shift amount from
// Rs[7:0]). Shifts STEP bits per cycle, stalls the pipeline while running and
// returns the shifted operand plus the shifter carry-out.
//
// Optional feature macro: SHIFT_CARRY_EN
//   defined     - carry_out is the ARM shifter carry
//   not defined - carry_out tied 0, carry_in unused; val_2 and timing unchanged
//
// Parameter:
//   STEP          bits shifted per SHIFT cycle (power of two, 1..32)
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   start         request, sampled only in IDLE or DONE
//   flush         abort current operation (priority over start)
//   rm    [31:0]  value to shift
//   rs    [31:0]  shift register, only rs[7:0] used
//   shift [1:0]   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   carry_in      current C flag
//   busy          high in SHIFT
//   stall         freeze IF/ID/EXE pipeline registers
//   done          one-cycle pulse, result valid
//   val_2 [31:0]  shifted operand, held until the next completion
//   carry_out     shifter carry, held with val_2
// ---------------------------------------------------------------------------
module reg_shift_sequencer
    import arm_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] rm,
    input  logic [31:0] rs,
    input  logic [1:0]  shift,
    input  logic        carry_in,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] val_2,
    output logic        carry_out
);

    localparam rem_t STEP_R = rem_t'(STEP);

    state_t      state_q, state_d;
    logic [1:0]  typ_q, typ_d;
    logic [31:0] wv_q, wv_d;
    rem_t        rem_q, rem_d;
    logic        over_q, over_d;
    logic [31:0] val2_q, val2_d;

    logic [7:0]  amt;
    rem_t        eff;
    logic        over_new;
    logic        ror_zero;
    logic        accept;
    rem_t        k;
    rem_t        rem_left;
    logic        force_zero;
    logic [31:0] step_val;
    logic        step_carry;

    assign amt = rs[7:0];

    // Effective amount: LSL/LSR/ASR saturate at 32 (over flags anything
    // larger); ROR only uses amt[4:0], with a non-zero multiple of 32 acting
    // as a zero-length rotate whose carry is rm[31].
    always_comb begin
        eff      = '0;
        over_new = 1'b0;
        ror_zero = 1'b0;
        if (shift == SH_ROR) begin
            eff      = {1'b0, amt[4:0]};
            ror_zero = (amt != 8'd0) && (amt[4:0] == 5'd0);
        end else if (amt > 8'd32) begin
            eff      = 6'd32;
            over_new = 1'b1;
        end else begin
            eff = amt[5:0];
        end
    end

    assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign k          = (rem_q < STEP_R) ? rem_q : STEP_R;
    assign rem_left   = rem_q - k;
    assign force_zero = over_q && (typ_q != SH_ASR);

    shift_step u_step (
        .val_i   (wv_q),
        .typ_i   (typ_q),
        .k_i     (k),
        .val_o   (step_val),
        .carry_o (step_carry)
    );

`ifdef SHIFT_CARRY_EN
    logic cy_q, cy_d;
`endif

    always_comb begin
        state_d = state_q;
        typ_d   = typ_q;
        wv_d    = wv_q;
        rem_d   = rem_q;
        over_d  = over_q;
        val2_d  = val2_q;
`ifdef SHIFT_CARRY_EN
        cy_d    = cy_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                wv_d  = step_val;
                rem_d = rem_left;
                // The final step's carry is the last bit out of the whole shift.
                if (rem_left == '0) begin
                    state_d = ST_DONE;
                    val2_d  = force_zero ? 32'h0 : step_val;
`ifdef SHIFT_CARRY_EN
                    cy_d    = force_zero ? 1'b0 : step_carry;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    typ_d  = shift;
                    wv_d   = rm;
                    rem_d  = eff;
                    over_d = over_new;
                    if (eff == '0) begin
                        state_d = ST_DONE;
                        val2_d  = rm;
`ifdef SHIFT_CARRY_EN
                        cy_d    = ror_zero ? rm[31] : carry_in;
`endif
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
        endcase
        // Abort: no result is published, the last completed one is kept.
        if (flush) begin
            state_d = ST_IDLE;
            val2_d  = val2_q;
`ifdef SHIFT_CARRY_EN
            cy_d    = cy_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            val2_q  <= 32'h0;
`ifdef SHIFT_CARRY_EN
            cy_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            val2_q  <= val2_d;
`ifdef SHIFT_CARRY_EN
            cy_q    <= cy_d;
`endif
        end
    end

    // Working registers are always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        typ_q  <= typ_d;
        wv_q   <= wv_d;
        rem_q  <= rem_d;
        over_q <= over_d;
    end

    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);
    assign stall = busy | (accept & (eff != '0));
    assign val_2 = val2_q;

`ifdef SHIFT_CARRY_EN
    assign carry_out = cy_q;
    logic unused_rs;
    assign unused_rs = ^rs[31:8];
`else
    assign carry_out = 1'b0;
    logic unused_carry;
    assign unused_carry = ^{rs[31:8], carry_in, step_carry, ror_zero};
`endif

endmodule

// File: tb/tb_reg_shift_sequencer.sv
module tb_reg_shift_sequencer;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rm = 32'h0;
    logic [31:0] rs = 32'h0;
    logic [1:0]  shift = 2'b00;
    logic        carry_in = 1'b0;
    logic        busy, stall, done, carry_out;
    logic [31:0] val_2;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_val;
    logic        exp_c;
    int          exp_lat;
    int          exp_eff;

    always #5 clk = ~clk;

    reg_shift_sequencer #(.STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .rm        (rm),
        .rs        (rs),
        .shift     (shift),
        .carry_in  (carry_in),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .val_2     (val_2),
        .carry_out (carry_out)
    );

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: ARM register-specified shift semantics, straight from the
    // shift amount, plus expected start-to-done latency.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                         input logic cin, output logic [31:0] v, output logic c,
                         output int lat, output int eff);
        int amt;
        int r;
        amt = int'(b[7:0]);
        case (s)
            2'b00: begin
                if (amt == 0)      begin v = a;         c = cin;       end
                else if (amt < 32) begin v = a << amt;  c = a[32-amt]; end
                else if (amt == 32) begin v = 32'h0;    c = a[0];      end
                else               begin v = 32'h0;     c = 1'b0;      end
                eff = (amt > 32) ? 32 : amt;
            end
            2'b01: begin
                if (amt == 0)      begin v = a;         c = cin;       end
                else if (amt < 32) begin v = a >> amt;  c = a[amt-1];  end
                else if (amt == 32) begin v = 32'h0;    c = a[31];     end
                else               begin v = 32'h0;     c = 1'b0;      end
                eff = (amt > 32) ? 32 : amt;
            end
            2'b10: begin
                if (amt == 0)      begin v = a;         c = cin;       end
                else if (amt < 32) begin v = $signed(a) >>> amt; c = a[amt-1]; end
                else               begin v = {32{a[31]}}; c = a[31];   end
                eff = (amt > 32) ? 32 : amt;
            end
            default: begin
                r = amt % 32;
                if (amt == 0)    begin v = a; c = cin;   end
                else if (r == 0) begin v = a; c = a[31]; end
                else begin
                    v = (a >> r) | (a << (32 - r));
                    c = a[r-1];
                end
                eff = r;
            end
        endcase
        lat = (eff == 0) ? 1 : ((eff + STEP - 1) / STEP) + 1;
`ifndef SHIFT_CARRY_EN
        c = 1'b0;
`endif
    endtask

    // Called at posedge+1 while the DUT is in IDLE or DONE.
    task automatic drive_start(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] s, input logic cin);
        rm = a; rs = b; shift = s; carry_in = cin; start = 1'b1;
        model(a, b, s, cin, exp_val, exp_c, exp_lat, exp_eff);
        #1;
        check({tag, "_stall_req"}, {31'h0, stall}, {31'h0, (exp_eff != 0)});
    endtask

    // noise=1 keeps start high with unrelated operands for one SHIFT edge.
    task automatic wait_done(input string tag, input bit noise);
        int cyc;
        tick();
        cyc = 1;
        if (noise) begin
            rm = 32'hFFFF_FFFF; rs = 32'd0; shift = 2'b11; carry_in = 1'b1;
            if (done !== 1'b1) begin
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin
            check({tag, "_busy"}, {31'h0, busy}, 32'd1);
            tick();
            cyc++;
        end
        check({tag, "_done"}, {31'h0, done}, 32'd1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_val_2"}, val_2, exp_val);
        check({tag, "_carry"}, {31'h0, carry_out}, {31'h0, exp_c});
        check({tag, "_stall_done"}, {31'h0, stall}, 32'd0);
    endtask

    task automatic done_drops(input string tag);
        tick();
        check({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] pv;
        logic        pc;
        logic [31:0] ra, rb, rsel;
        int          amt;

        // Reset
        rst = 1'b0;
        tick();
        tick();
        check("rst_busy",  {31'h0, busy},      32'd0);
        check("rst_stall", {31'h0, stall},     32'd0);
        check("rst_done",  {31'h0, done},      32'd0);
        check("rst_carry", {31'h0, carry_out}, 32'd0);
        check("rst_val_2", val_2,              32'h0);
        rst = 1'b1;
        tick();

        // Directed cases
        drive_start("lsl8", 32'h0000_00F1, 32'd8, 2'b00, 1'b1);
        wait_done("lsl8", 1'b0);
        check("lsl8_const", val_2, 32'h0000_F100);
        done_drops("lsl8");

        drive_start("lsr33", 32'h8000_0001, 32'd33, 2'b01, 1'b1);
        wait_done("lsr33", 1'b0);
        check("lsr33_const", val_2, 32'h0);
        done_drops("lsr33");

        drive_start("lsr32", 32'h8000_0001, 32'd32, 2'b01, 1'b0);
        wait_done("lsr32", 1'b0);
        done_drops("lsr32");

        drive_start("asr40", 32'h8000_0000, 32'd40, 2'b10, 1'b0);
        wait_done("asr40", 1'b0);
        check("asr40_const", val_2, 32'hFFFF_FFFF);
        done_drops("asr40");

        drive_start("ror32", 32'h0000_0001, 32'd32, 2'b11, 1'b1);
        wait_done("ror32", 1'b0);
        done_drops("ror32");

        drive_start("ror64", 32'h8000_0000, 32'd64, 2'b11, 1'b0);
        wait_done("ror64", 1'b0);
        done_drops("ror64");

        drive_start("zero", 32'h1234_5678, 32'hFFFF_FF00, 2'b00, 1'b1);
        wait_done("zero", 1'b0);
        done_drops("zero");

        // start during SHIFT is ignored
        drive_start("ignore", 32'h0000_00A5, 32'd12, 2'b00, 1'b0);
        wait_done("ignore", 1'b1);
        done_drops("ignore");

        // flush in the second SHIFT cycle
        pv = exp_val;
        pc = exp_c;
        drive_start("flush", 32'hFFFF_0001, 32'd12, 2'b00, 1'b1);
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy",  {31'h0, busy},      32'd0);
        check("flush_done",  {31'h0, done},      32'd0);
        check("flush_val_2", val_2,              pv);
        check("flush_carry", {31'h0, carry_out}, {31'h0, pc});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_no_done", {31'h0, done}, 32'd0);
        end

        // reset mid-SHIFT
        drive_start("rstmid", 32'hDEAD_BEEF, 32'd20, 2'b11, 1'b1);
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_busy",  {31'h0, busy},      32'd0);
        check("rstmid_stall", {31'h0, stall},     32'd0);
        check("rstmid_done",  {31'h0, done},      32'd0);
        check("rstmid_carry", {31'h0, carry_out}, 32'd0);
        check("rstmid_val_2", val_2,              32'h0);
        rst = 1'b1;
        tick();

        // back-to-back: start accepted in the DONE cycle
        drive_start("b2b_a", 32'h0F0F_0F0F, 32'd7, 2'b10, 1'b0);
        wait_done("b2b_a", 1'b0);
        drive_start("b2b_b", 32'h8765_4321, 32'd17, 2'b11, 1'b1);
        wait_done("b2b_b", 1'b0);
        done_drops("b2b_b");

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            ra   = $urandom;
            rb   = $urandom;
            rsel = $urandom_range(0, 3);
            case (rsel)
                0:       amt = $urandom_range(0, 40);
                1:       amt = 32 * $urandom_range(0, 7);
                2:       amt = $urandom_range(0, 255);
                default: amt = $urandom_range(1, 31);
            endcase
            rb[7:0] = amt[7:0];
            drive_start("rand", ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            wait_done("rand", 1'b0);
            if ($urandom_range(0, 1) == 1) done_drops("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
